// File: rtl/node_types_pkg.sv
// Shared encoding for switch-level node words: strength[2:1], level[0].
// Used by the node resolution stage and its max-reduction helper.
package node_types_pkg;

  localparam int W = 3;

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_FLOAT  = 2'b01;
  localparam logic [1:0] S_WEAK   = 2'b10;
  localparam logic [1:0] S_STRONG = 2'b11;

  localparam logic L_HI = 1'b0;
  localparam logic L_LO = 1'b1;

  // Weak or strong drive: the top strength bit is set.
  function automatic logic is_driven(input logic [W-1:0] word);
    return word[2];
  endfunction

  // Logic level seen by a transistor gate: high only when some strength is present.
  function automatic logic level_bit(input logic [W-1:0] word);
    return (word[2:1] != S_OFF) && (word[0] == L_HI);
  endfunction

endpackage

// File: rtl/node_max_tree.sv
// Combinational unsigned-max reduction over N packed words of width W.
// Word i occupies words[i*W +: W]. With W=1 it degenerates to an OR.
module node_max_tree #(
  parameter int W = 3,
  parameter int N = 4
) (
  input  logic [N*W-1:0] words,
  output logic [W-1:0]   max_word
);

  // Linear scan keeping the largest word seen so far.
  always_comb begin
    // NOTE: blocking assignments here because each iteration must see the
    // running maximum produced by the previous one within the same evaluation.
    max_word = '0;
    for (int i = 0; i < N; i++) begin
      if (words[i*W +: W] > max_word) begin
        max_word = words[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/node_charge_store.sv
// Net-resolution stage with charge storage for one electrical node.
// All drivers are max-resolved; once released, the node floats at its last
// level and decays to undriven after DECAY_CYCLES evaluation steps
// (0 = never decays).
// Optional: define NODE_CONFLICT_DETECT_EN to flag strong1/strong0 fights.
module node_charge_store
  import node_types_pkg::*;
#(
  parameter int W            = 3,
  parameter int N_DRV        = 4,
  parameter int DECAY_CYCLES = 64,
  parameter int CNT_W        = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               eval,
  input  logic [N_DRV*W-1:0] drv_in,
  output logic [W-1:0]       node_out,
  output logic               node_bit,
  output logic               charged,
  output logic               decayed,
  output logic               conflict
);

  localparam logic [CNT_W-1:0] RELOAD =
    (DECAY_CYCLES > 1) ? CNT_W'(DECAY_CYCLES - 1) : '0;

  logic [W-1:0]     res;
  logic [W-1:0]     hold_word;
  logic [W-1:0]     cand;
  logic [W-1:0]     node_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             decayed_nxt;

  node_max_tree #(.W(W), .N(N_DRV)) u_res (
    .words    (drv_in),
    .max_word (res)
  );

  // Held charge competes with any floating input; float0 beats float1.
  assign hold_word = {S_FLOAT, node_out[0]};

  node_max_tree #(.W(W), .N(2)) u_cand (
    .words    ({res, hold_word}),
    .max_word (cand)
  );

  assign node_bit = level_bit(node_out);

  // Next-state selection: driven, rising from undriven, holding, or decaying.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    node_nxt    = node_out;
    cnt_nxt     = cnt_q;
    decayed_nxt = 1'b0;
    if (is_driven(res)) begin
      node_nxt = res;
      cnt_nxt  = RELOAD;
    end else if (node_out[2:1] == S_OFF) begin
      node_nxt = res;
      cnt_nxt  = (res[2:1] == S_FLOAT) ? RELOAD : '0;
    end else if (cnt_q != '0 || DECAY_CYCLES == 0) begin
      node_nxt = cand;
      cnt_nxt  = (DECAY_CYCLES == 0) ? '0 : cnt_q - 1'b1;
    end else begin
      node_nxt    = '0;
      cnt_nxt     = '0;
      decayed_nxt = 1'b1;
    end
  end

  // State registers; update only on eval, decayed pulse self-clears.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      node_out <= '0;
      cnt_q    <= '0;
      charged  <= 1'b0;
      decayed  <= 1'b0;
    end else if (eval) begin
      node_out <= node_nxt;
      cnt_q    <= cnt_nxt;
      charged  <= (node_nxt[2:1] == S_FLOAT);
      decayed  <= decayed_nxt;
    end else begin
      decayed  <= 1'b0;
    end
  end

`ifdef NODE_CONFLICT_DETECT_EN
  logic [N_DRV-1:0] is_s1;
  logic [N_DRV-1:0] is_s0;
  logic             any_s1;
  logic             any_s0;

  // Per-driver strong1/strong0 flags.
  always_comb begin
    is_s1 = '0;
    is_s0 = '0;
    for (int i = 0; i < N_DRV; i++) begin
      is_s1[i] = (drv_in[i*W +: W] == {S_STRONG, L_HI});
      is_s0[i] = (drv_in[i*W +: W] == {S_STRONG, L_LO});
    end
  end

  node_max_tree #(.W(1), .N(N_DRV)) u_any_s1 (
    .words    (is_s1),
    .max_word (any_s1)
  );

  node_max_tree #(.W(1), .N(N_DRV)) u_any_s0 (
    .words    (is_s0),
    .max_word (any_s0)
  );

  // Conflict flag follows the drivers of the last eval edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else if (eval) begin
      conflict <= any_s1 & any_s0;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule
